// File: rtl/bp_me_cache_dma_mem.sv
// Behavioural DMA memory that serves block fills and evictions for a cache.
// Define BP_ME_CACHE_DMA_MEM_DELAY_EN to insert a delay_p-cycle wait after each accepted packet.
//
// state   | meaning
// e_ready | waiting for a DMA packet
// e_delay | response wait after accept (delay build only)
// e_read  | streaming fill beats to the cache
// e_write | absorbing evict beats from the cache
module bp_me_cache_dma_mem #(
    parameter int daddr_width_p         = 32,
    parameter int word_width_p          = 64,
    parameter int block_size_in_words_p = 8,
    parameter int dma_data_width_p      = 64,
    parameter int mem_els_p             = 1024,
    parameter int delay_p               = 8
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [daddr_width_p:0]      dma_pkt_i,
    input  logic                        dma_pkt_v_i,
    output logic                        dma_pkt_ready_and_o,
    output logic [dma_data_width_p-1:0] dma_data_o,
    output logic                        dma_data_v_o,
    input  logic                        dma_data_ready_and_i,
    input  logic [dma_data_width_p-1:0] dma_data_i,
    input  logic                        dma_data_v_i,
    output logic                        dma_data_ready_and_o
);

    localparam int beats_lp        = block_size_in_words_p * word_width_p / dma_data_width_p;
    localparam int block_bytes_lp  = block_size_in_words_p * word_width_p / 8;
    localparam int offset_width_lp = $clog2(block_bytes_lp);
    localparam int slot_width_lp   = $clog2(mem_els_p);
    localparam int beat_width_lp   = (beats_lp > 1) ? $clog2(beats_lp) : 1;
    localparam logic [beat_width_lp-1:0] last_beat_lp = beat_width_lp'(beats_lp - 1);

`ifdef BP_ME_CACHE_DMA_MEM_DELAY_EN
    typedef enum logic [1:0] {e_ready = 2'd0, e_delay = 2'd1, e_read = 2'd2, e_write = 2'd3} state_e;
`else
    typedef enum logic [1:0] {e_ready = 2'd0, e_read = 2'd2, e_write = 2'd3} state_e;
`endif

    state_e state_r, state_n;

    logic                         write_not_read_r;
    logic [slot_width_lp-1:0]     block_r;
    logic [beat_width_lp-1:0]     beat_r;
    logic [slot_width_lp-1:0]     slot;
    logic [dma_data_width_p-1:0]  mem_r [mem_els_p];

    logic pkt_accept, rd_fire, wr_fire, beat_fire, last_fire;
    logic unused_addr_bits;

    assign pkt_accept = dma_pkt_v_i & dma_pkt_ready_and_o;
    assign rd_fire    = dma_data_v_o & dma_data_ready_and_i;
    assign wr_fire    = dma_data_v_i & dma_data_ready_and_o;
    assign beat_fire  = rd_fire | wr_fire;
    assign last_fire  = beat_fire & (beat_r == last_beat_lp);

    // Only the low block-index bits matter: slots wrap modulo mem_els_p, so high addresses alias.
    assign slot = block_r * slot_width_lp'(beats_lp) + slot_width_lp'(beat_r);
    assign unused_addr_bits = ^{dma_pkt_i[offset_width_lp-1:0],
                                dma_pkt_i[daddr_width_p-1:offset_width_lp+slot_width_lp]};

`ifdef BP_ME_CACHE_DMA_MEM_DELAY_EN
    localparam int delay_width_lp = (delay_p > 1) ? $clog2(delay_p) : 1;
    localparam bit has_delay_lp   = (delay_p > 0);

    logic [delay_width_lp-1:0] delay_r;
    logic                      delay_done;

    assign delay_done = (delay_r == '0);

    always_ff @(posedge clk_i) begin
        if (reset_i)
            delay_r <= '0;
        else if (pkt_accept)
            delay_r <= delay_width_lp'(delay_p - 1);
        else if ((state_r == e_delay) && !delay_done)
            delay_r <= delay_r - delay_width_lp'(1);
    end
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i)
            state_r <= e_ready;
        else
            state_r <= state_n;
    end

    always_comb begin
        state_n = state_r;
        case (state_r)
            e_ready: begin
                if (pkt_accept) begin
`ifdef BP_ME_CACHE_DMA_MEM_DELAY_EN
                    if (has_delay_lp)
                        state_n = e_delay;
                    else
`endif
                    state_n = dma_pkt_i[daddr_width_p] ? e_write : e_read;
                end
            end
`ifdef BP_ME_CACHE_DMA_MEM_DELAY_EN
            e_delay: if (delay_done) state_n = write_not_read_r ? e_write : e_read;
`endif
            e_read:  if (last_fire) state_n = e_ready;
            e_write: if (last_fire) state_n = e_ready;
            default: state_n = e_ready;
        endcase
    end

    always_comb begin
        dma_pkt_ready_and_o  = 1'b0;
        dma_data_v_o         = 1'b0;
        dma_data_ready_and_o = 1'b0;
        case (state_r)
            e_ready: dma_pkt_ready_and_o  = 1'b1;
            e_read:  dma_data_v_o         = 1'b1;
            e_write: dma_data_ready_and_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            write_not_read_r <= 1'b0;
            block_r          <= '0;
            beat_r           <= '0;
        end else if (pkt_accept) begin
            write_not_read_r <= dma_pkt_i[daddr_width_p];
            block_r          <= dma_pkt_i[offset_width_lp +: slot_width_lp];
            beat_r           <= '0;
        end else if (beat_fire) begin
            beat_r <= last_fire ? '0 : beat_r + beat_width_lp'(1);
        end
    end

    // Storage is intentionally left unreset.
    always_ff @(posedge clk_i) begin
        if (wr_fire)
            mem_r[slot] <= dma_data_i;
    end

    assign dma_data_o = mem_r[slot];

endmodule

// File: doc/bp_me_cache_dma_mem.md
BP_ME_CACHE_DMA_MEM -- requirements
Module: bp_me_cache_dma_mem

Interface
REQ-001 SHALL have parameter daddr_width_p, default 32: DMA address width in bytes.
REQ-002 SHALL have parameter word_width_p, default 64: cache word width.
REQ-003 SHALL have parameter block_size_in_words_p, default 8: words per cache block.
REQ-004 SHALL have parameter dma_data_width_p, default 64: fill/evict beat width; beats-per-block B = block_size_in_words_p*word_width_p/dma_data_width_p.
REQ-005 SHALL have parameter mem_els_p, default 1024: stored beats; power of two, multiple of B.
REQ-006 SHALL have parameter delay_p, default 8: response delay in cycles, used only under REQ-024.
REQ-007 SHALL have port clk_i, input, 1: the single clock.
REQ-008 SHALL have port reset_i, input, 1: synchronous, active-high reset.
REQ-009 SHALL have port dma_pkt_i, input, 1+daddr_width_p: bit [daddr_width_p] = write_not_read; bits [daddr_width_p-1:0] = byte address.
REQ-010 SHALL have ports dma_pkt_v_i, input, 1, and dma_pkt_ready_and_o, output, 1: packet valid/ready handshake.
REQ-011 SHALL have ports dma_data_o, output, dma_data_width_p; dma_data_v_o, output, 1; and dma_data_ready_and_i, input, 1: fill beats returned to the cache.
REQ-012 SHALL have ports dma_data_i, input, dma_data_width_p; dma_data_v_i, input, 1; and dma_data_ready_and_o, output, 1: evict beats from the cache.

Function
REQ-013 SHALL implement a state machine with states e_ready, e_delay, e_read and e_write.
REQ-014 In e_ready, SHALL drive dma_pkt_ready_and_o=1 and latch the packet on dma_pkt_v_i&dma_pkt_ready_and_o; dma_pkt_ready_and_o SHALL be 0 in every other state.
REQ-015 SHALL compute the block index as addr >> log2(block_size_in_words_p*word_width_p/8), ignoring the low offset bits.
REQ-016 SHALL use beat slot ((block index*B)+beat count) mod mem_els_p, so high addresses alias (wrap) silently.
REQ-017 After the accept cycle, SHALL move to e_read if write_not_read=0, else to e_write (or to e_delay per REQ-024).
REQ-018 In e_read, SHALL drive dma_data_v_o=1 with the beat at the current slot; the first beat SHALL be valid the cycle after accept; reads SHALL be asynchronous from the flop/latch array.
REQ-019 SHALL advance the beat count on each dma_data_v_o&dma_data_ready_and_i; dma_data_o SHALL hold stable while stalled.
REQ-020 In e_write, SHALL drive dma_data_ready_and_o=1 and write dma_data_i to the current slot on each dma_data_v_i&dma_data_ready_and_o.
REQ-021 SHALL return to e_ready on the handshake of beat B-1; the next packet SHALL be acceptable the following cycle.
REQ-022 Outside e_read, SHALL hold dma_data_v_o=0; outside e_write, SHALL hold dma_data_ready_and_o=0 and ignore dma_data_v_i.

Reset
REQ-023 While reset_i=1 at a clock edge, SHALL go to e_ready and clear the beat count; from the following cycle, dma_pkt_ready_and_o=1, dma_data_v_o=0 and dma_data_ready_and_o=0; a mid-transfer reset SHALL abandon the transfer; memory contents SHALL be left unreset (undefined).

Configuration
REQ-024 With BP_ME_CACHE_DMA_MEM_DELAY_EN defined, accept SHALL enter e_delay, count delay_p cycles, then enter e_read or e_write, so the first read beat is valid exactly delay_p+1 cycles after accept; without the macro, e_delay and its counter SHALL be absent and REQ-017 timing applies.

Verification
REQ-025 Write pkt addr 0x40, beats 0x1000..0x1007; then read pkt 0x40 -> fill beats 0x1000..0x1007 in order, first beat valid 1 cycle after accept (macro off).
REQ-026 Read 0x40 with dma_data_ready_and_i low on cycles 2-4 -> dma_data_o holds 0x1001 stable; exactly 8 handshakes delivered; return to e_ready.
REQ-027 Write 0x40, then read 0x10040 (defaults: mem_els_p*B... aliases block 1) -> returns 0x1000..0x1007 (wrap).
REQ-028 Assert dma_pkt_v_i with a second packet during a read -> dma_pkt_ready_and_o=0 until the cycle after the last beat, then accepted.
REQ-029 Assert reset_i after beat 3 of a read -> next cycle dma_data_v_o=0 and dma_pkt_ready_and_o=1; a new read completes with 8 beats.
REQ-030 With BP_ME_CACHE_DMA_MEM_DELAY_EN and delay_p=8: read accepted cycle N -> first dma_data_v_o=1 at cycle N+9; write -> dma_data_ready_and_o first 1 at cycle N+9.
